// File: rtl/fc_neuron_mac.sv
// Sequential signed fixed-point dot product with bias and saturation for one FC neuron.
// Optional build macro FC_MAC_RELU_EN applies ReLU to the saturated result.
module fc_neuron_mac #(
    parameter int BUFFER_SIZE       = 120,
    parameter int WORD_SIZE         = 16,
    parameter int FRAC_BITS         = 8,
    parameter int MEM_ADDRESS_WIDTH = 10
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_start,
    input  logic [MEM_ADDRESS_WIDTH-1:0]       i_count,
    input  logic [WORD_SIZE*BUFFER_SIZE-1:0]   i_inputs,
    input  logic [WORD_SIZE*BUFFER_SIZE-1:0]   i_weights,
    input  logic [WORD_SIZE-1:0]               i_bias,
    output logic [WORD_SIZE-1:0]               o_result,
    output logic                               o_valid,
    output logic                               o_busy
);

    localparam int IDX_W = $clog2(BUFFER_SIZE + 1);
    localparam int ACC_W = 2 * WORD_SIZE + $clog2(BUFFER_SIZE) + 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - WORD_SIZE + 1){1'b0}}, {(WORD_SIZE - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W - WORD_SIZE + 1){1'b1}}, {(WORD_SIZE - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FINISH
    } state_t;

    state_t                     state;
    logic [IDX_W-1:0]           idx;
    logic [IDX_W-1:0]           len;
    logic signed [ACC_W-1:0]    acc;

    logic [IDX_W-1:0]           rd_idx;
    logic signed [WORD_SIZE-1:0]   in_word;
    logic signed [WORD_SIZE-1:0]   w_word;
    logic signed [2*WORD_SIZE-1:0] prod;
    logic signed [ACC_W-1:0]    shifted;
    logic [WORD_SIZE-1:0]       sat_val;
    logic [WORD_SIZE-1:0]       final_val;

    always_comb begin
        // Index is forced to 0 outside ACCUM so idx==BUFFER_SIZE never reaches the select.
        rd_idx  = (state == ACCUM) ? idx : '0;
        in_word = i_inputs[int'(rd_idx) * WORD_SIZE +: WORD_SIZE];
        w_word  = i_weights[int'(rd_idx) * WORD_SIZE +: WORD_SIZE];
        prod    = in_word * w_word;
        shifted = acc >>> FRAC_BITS;
        if (shifted > SAT_MAX) begin
            sat_val = SAT_MAX[WORD_SIZE-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_val = SAT_MIN[WORD_SIZE-1:0];
        end else begin
            sat_val = shifted[WORD_SIZE-1:0];
        end
        final_val = sat_val;
`ifdef FC_MAC_RELU_EN
        if (sat_val[WORD_SIZE-1]) begin
            final_val = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            len      <= '0;
            acc      <= '0;
            o_result <= '0;
            o_valid  <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_valid <= 1'b0;
                    if (i_start) begin
                        len <= (i_count > MEM_ADDRESS_WIDTH'(BUFFER_SIZE)) ?
                               IDX_W'(BUFFER_SIZE) : i_count[IDX_W-1:0];
                        acc <= {{(ACC_W - WORD_SIZE - FRAC_BITS){i_bias[WORD_SIZE-1]}},
                                i_bias, {FRAC_BITS{1'b0}}};
                        idx    <= '0;
                        o_busy <= 1'b1;
                        state  <= (i_count == '0) ? FINISH : ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc + {{(ACC_W - 2 * WORD_SIZE){prod[2*WORD_SIZE-1]}}, prod};
                    idx <= idx + 1'b1;
                    if (idx == len - 1'b1) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    o_result <= final_val;
                    o_valid  <= 1'b1;
                    o_busy   <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_neuron_mac.sv
// Directed bench for fc_neuron_mac: latency, arithmetic, saturation, flooring, restart, clamp, reset.
module tb_fc_neuron_mac;

    localparam int BS = 120;
    localparam int WS = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [9:0]      count;
    logic [WS*BS-1:0] inputs;
    logic [WS*BS-1:0] weights;
    logic [WS-1:0]   bias;
    logic [WS-1:0]   result;
    logic            valid;
    logic            busy;

    int errors = 0;
    int checks = 0;
    int lat;
    int seen_valid;

    fc_neuron_mac #(
        .BUFFER_SIZE(BS),
        .WORD_SIZE(WS),
        .FRAC_BITS(8),
        .MEM_ADDRESS_WIDTH(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_start(start),
        .i_count(count),
        .i_inputs(inputs),
        .i_weights(weights),
        .i_bias(bias),
        .o_result(result),
        .o_valid(valid),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_bufs();
        inputs  = '0;
        weights = '0;
    endtask

    task automatic set_entry(input int i, input logic [WS-1:0] a, input logic [WS-1:0] w);
        inputs[i*WS +: WS]  = a;
        weights[i*WS +: WS] = w;
    endtask

    // Issues a one-cycle start and returns edges from the start edge to the o_valid edge.
    task automatic run(input logic [9:0] cnt, input logic [WS-1:0] b, output int edges);
        count = cnt;
        bias  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = -1;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (valid) begin
                edges = k;
                break;
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        count = '0;
        bias  = '0;
        clear_bufs();
        tick();
        tick();
        check("reset_result", $signed(result), 0);
        check("reset_valid", valid, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        tick();

        // Test 1: basic dot product with cycle-by-cycle handshake.
        set_entry(0, 16'd256, 16'd256);
        set_entry(1, 16'd512, 16'd256);
        set_entry(2, 16'd768, 16'd256);
        count = 10'd3;
        bias  = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("t1_busy", busy, 1);
            check("t1_novalid", valid, 0);
            tick();
        end
        check("t1_valid", valid, 1);
        check("t1_result", $signed(result), 1536);
        check("t1_busy_done", busy, 0);
        tick();
        check("t1_valid_pulse", valid, 0);
        check("t1_result_held", $signed(result), 1536);

        // Test 2: zero-length vector gives bias only.
        run(10'd0, 16'hFF80, lat);
        check("t2_latency", lat, 1);
`ifdef FC_MAC_RELU_EN
        check("t2_result", $signed(result), 0);
`else
        check("t2_result", $signed(result), -128);
`endif

        // Test 3: positive and negative saturation.
        for (int i = 0; i < 4; i++) set_entry(i, 16'h7FFF, 16'h7FFF);
        run(10'd4, 16'h7FFF, lat);
        check("t3_latency", lat, 5);
        check("t3_pos_sat", $signed(result), 32767);
        for (int i = 0; i < 4; i++) set_entry(i, 16'h8000, 16'h7FFF);
        run(10'd4, 16'h7FFF, lat);
        check("t3n_latency", lat, 5);
`ifdef FC_MAC_RELU_EN
        check("t3_neg_sat", $signed(result), 0);
`else
        check("t3_neg_sat", $signed(result), -32768);
`endif

        // Test 4: arithmetic shift floors -1/256 to -1.
        clear_bufs();
        set_entry(0, 16'hFFFF, 16'h0001);
        set_entry(1, 16'h0000, 16'h0000);
        run(10'd2, 16'h0000, lat);
        check("t4_latency", lat, 3);
`ifdef FC_MAC_RELU_EN
        check("t4_floor", $signed(result), 0);
`else
        check("t4_floor", $signed(result), -1);
`endif

        // Test 5: start during ACCUM is ignored; back-to-back start after o_valid accepted.
        set_entry(0, 16'd256, 16'd256);
        set_entry(1, 16'd512, 16'd256);
        set_entry(2, 16'd768, 16'd256);
        count = 10'd3;
        bias  = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        count = 10'd1;
        bias  = 16'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_busy_mid", busy, 1);
        lat = -1;
        for (int k = 3; k <= 20; k++) begin
            tick();
            if (valid) begin
                lat = k;
                break;
            end
        end
        check("t5_latency", lat, 4);
        check("t5_result", $signed(result), 1536);
        run(10'd1, 16'd100, lat);
        check("t5_restart_latency", lat, 2);
        check("t5_restart_result", $signed(result), 356);

        // Test 6: oversize count clamps to buffer length.
        for (int i = 0; i < BS; i++) set_entry(i, 16'd256, 16'd256);
        run(10'd200, 16'h0000, lat);
        check("t6_latency", lat, 121);
        check("t6_result", $signed(result), 30720);

        // Reset at idx=50 aborts with no o_valid.
        count = 10'd200;
        bias  = 16'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 50; k++) tick();
        check("t6_busy_before_rst", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_valid", valid, 0);
        check("t6_rst_result", $signed(result), 0);
        seen_valid = 0;
        for (int k = 0; k < 130; k++) begin
            tick();
            if (valid || busy) seen_valid = 1;
        end
        check("t6_no_valid_after_rst", seen_valid, 0);

        // Engine is usable again after the abort.
        clear_bufs();
        set_entry(0, 16'd512, 16'd512);
        run(10'd1, 16'h0000, lat);
        check("post_rst_latency", lat, 2);
        check("post_rst_result", $signed(result), 1024);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
